// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit with one outstanding memory request,
// a 2-entry instruction FIFO and redirect/flush handling.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [6:0]  Op,
    output logic [2:0]  Funct3,
    output logic [6:0]  Funct7
);
    logic [31:0] fetch_pc;
    logic [31:0] pc_q   [2];
    logic [31:0] word_q [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count, count_nxt;
    logic        outstanding, discard;
    logic        rsp, push, pop, issue;

    always_comb begin
        rsp       = imem_rvalid & outstanding;
        push      = rsp & ~discard & ~redirect_valid;
        pop       = inst_valid & inst_ready;
        count_nxt = count + {1'b0, push} - {1'b0, pop};
        // A response completing at this edge frees the slot, so a 1-cycle
        // memory sustains one fetch every two cycles.
        issue     = ~redirect_valid & ~imem_req & (~outstanding | rsp) & (count_nxt != 2'd2);
    end

    assign inst_valid = (count != 2'd0);
    assign inst_out   = word_q[rd_ptr];
    assign inst_pc    = pc_q[rd_ptr];
    assign Op         = inst_out[6:0];
    assign Funct3     = inst_out[14:12];
    assign Funct7     = inst_out[31:25];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else begin
            imem_req    <= issue;
            outstanding <= issue | (outstanding & ~imem_rvalid);
            discard     <= redirect_valid ? (outstanding & ~imem_rvalid) : (discard & ~rsp);
            if (redirect_valid) begin
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else begin
                count <= count_nxt;
                if (push) wr_ptr <= ~wr_ptr;
                if (pop) rd_ptr <= ~rd_ptr;
            end
            // imem_addr holds the request address until the next issue,
            // so it doubles as the pc of the outstanding response.
            if (issue) begin
                imem_addr <= fetch_pc;
                fetch_pc  <= fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= imem_addr;
            word_q[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench; memory model answers requests with addr^A5A5_0000,
// expected pc stream is rebuilt on every reset/redirect.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [6:0]  Op;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc),
        .Op(Op), .Funct3(Funct3), .Funct7(Funct7)
    );

    int          tests = 0, fails = 0;
    logic [31:0] exp_q [$];
    logic [31:0] req_exp, pend_addr;
    bit          pend, prev_req, rand_lat;
    int          pend_cnt, lat = 1, req_cnt = 0, pops = 0;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(pc + 32'(4 * i));
        req_exp = pc;
    endtask

    // One clock: account for what happened at the edge, then run the memory model.
    task automatic step();
        @(posedge clk);
        #1;
        if (redirect_valid) restart(redirect_pc & 32'hFFFF_FFFC);
        imem_rvalid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = hash(pend_addr);
                pend        = 1'b0;
            end
        end
        if (imem_req) begin
            req_cnt++;
            check("req_addr", imem_addr, req_exp);
            check("req_gap", {31'b0, prev_req}, 32'd0);
            req_exp  += 32'd4;
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
        end
        prev_req = imem_req;
        while (exp_q.size() != 0 && exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        pend           = 1'b0;
        prev_req       = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        restart(RESET_PC);
    endtask

    // Monitor: the head shown must be the front of the expected stream.
    initial begin : monitor
        logic [31:0] e, w;
        forever begin
            @(negedge clk);
            if (rstn && inst_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL queue_empty: got pc %h expected none", inst_pc);
                end else begin
                    e = exp_q[0];
                    w = hash(e);
                    check("inst_pc", inst_pc, e);
                    check("inst_out", inst_out, w);
                    check("fields", {15'b0, Op, Funct3, Funct7}, {15'b0, w[6:0], w[14:12], w[31:25]});
                    if (inst_ready && !redirect_valid) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rstn = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1; rand_lat = 1'b0;
        #2;
        do_reset();

        // First fetch, latency and throughput with a 1-cycle memory
        lat = 1;
        step();
        check("first_req", {31'b0, imem_req}, 32'd1);
        step();
        check("lat_not_yet", {31'b0, inst_valid}, 32'd0);
        step();
        check("lat_visible", {31'b0, inst_valid}, 32'd1);
        req_cnt = 0;
        repeat (10) step();
        check("throughput", 32'(req_cnt), 32'd5);
        check("seq_pops", {31'b0, pops >= 3}, 32'd1);

        // Back-pressure fills the FIFO and stops fetching
        do_reset();
        inst_ready = 1'b0;
        req_cnt = 0;
        repeat (10) step();
        check("stall_reqs", 32'(req_cnt), 32'd2);
        check("stall_valid", {31'b0, inst_valid}, 32'd1);
        check("stall_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        p0 = pops;
        repeat (12) step();
        check("drain", {31'b0, (pops - p0) >= 3}, 32'd1);

        // Redirect while a 3-cycle response is in flight
        lat = 3;
        for (int i = 0; i < 20 && !imem_req; i++) step();
        check("wait_req31", {31'b0, imem_req}, 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !imem_req; i++) step();
        check("redir_addr", imem_addr, 32'h100);
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        check("redir_pc", inst_pc, 32'h100);

        // Redirect coinciding with a response and a pop
        lat = 1;
        inst_ready = 1'b0;
        for (int i = 0; i < 30 && !(imem_rvalid && inst_valid); i++) step();
        check("setup32", {31'b0, imem_rvalid && inst_valid}, 32'd1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check("flush_empty", {31'b0, inst_valid}, 32'd0);
        check("no_req_redirect", {31'b0, imem_req}, 32'd0);
        step();
        check("req_after_flush", {31'b0, imem_req}, 32'd1);
        check("flush_addr", imem_addr, 32'h200);

        // Address wrap past 0xFFFF_FFFC (low bits of redirect_pc ignored)
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !imem_req; i++) step();
        check("wrap_first", imem_addr, 32'hFFFF_FFFC);
        step();
        for (int i = 0; i < 20 && !imem_req; i++) step();
        check("wrap_next", imem_addr, 32'h0);
        repeat (6) step();

        // Reset while a request is outstanding
        lat = 3;
        for (int i = 0; i < 20 && !imem_req; i++) step();
        step();
        do_reset();
        step();
        check("post_rst_req", {31'b0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, RESET_PC);

        // Randomized traffic
        rand_lat = 1'b1;
        p0 = pops;
        repeat (1500) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        check("rand_progress", {31'b0, (pops - p0) > 100}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  sole clock; all flops on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous and active-low.
REQ-004 imem_req  output  1  one-cycle fetch request to instruction memory; registered.
REQ-005 imem_addr  output  32  word address of the request; registered; valid while imem_req=1.
REQ-006 imem_rvalid  input  1  response strobe; arrives at least 1 cycle after the imem_req cycle.
REQ-007 imem_rdata  input  32  instruction word; valid with imem_rvalid.
REQ-008 redirect_valid  input  1  flush and restart fetch (branch/jump taken).
REQ-009 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 00.
REQ-010 inst_valid  output  1  head instruction available to the decoder.
REQ-011 inst_ready  input  1  decoder accepts the head instruction.
REQ-012 inst_out  output  32  head instruction word.
REQ-013 inst_pc  output  32  PC of the head instruction.
REQ-014 Op / Funct3 / Funct7  output  7/3/7  inst_out[6:0] / [14:12] / [31:25], combinational, feeding the control decoder.

Function
REQ-015 Internal state: fetch_pc (32), 2-entry FIFO of {pc, word}, count (0..2), outstanding flag, discard flag.
REQ-016 Issue condition at a rising edge: outstanding=0, count<2, redirect_valid=0; then imem_req<=1, imem_addr<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32 wrap), outstanding<=1.
REQ-017 When the issue condition is false, imem_req<=0; imem_req is never high two consecutive cycles.
REQ-018 Response: on imem_rvalid=1 with discard=0, push {pc of request, imem_rdata}; outstanding<=0 in either case; discard<=0.
REQ-019 Credit rule: count+outstanding never exceeds 2, so a push never meets a full FIFO; imem_rvalid with outstanding=0 is ignored.
REQ-020 inst_valid = (count!=0); inst_out/inst_pc show the FIFO head; pop on inst_valid & inst_ready.
REQ-021 Push and pop in the same cycle: count unchanged; an arriving word may bypass nothing and appears at inst_out no earlier than the next cycle.
REQ-022 Redirect (redirect_valid=1 at an edge): count<=0; fetch_pc<={redirect_pc[31:2],2'b00}; no request issued that cycle; if outstanding=1 or an imem_rvalid arrives that same cycle, that response is not pushed; if a response is still pending, discard<=1.
REQ-023 Redirect has priority over simultaneous pop, push and issue.
REQ-024 Latency: with 1-cycle memory and inst_ready=1, the first instruction is visible 2 cycles after the first imem_req; sustained throughput is one instruction per 2 cycles.
REQ-025 Back-pressure: inst_ready=0 holds inst_out, inst_pc stable while inst_valid=1.

Reset
REQ-026 While rstn=0: imem_req=0, imem_addr=0, inst_valid=0, count=0, outstanding=0, discard=0, fetch_pc=RESET_PC.
REQ-027 First request is issued at the first rising edge after rstn deasserts, with imem_addr=RESET_PC.
REQ-028 Reset asserted mid-transaction: the pending response is dropped; after release fetch restarts at RESET_PC.

Verification
REQ-029 Reset release, 1-cycle memory returning addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8, inst_out 0xA5A5_0000, 0xA5A5_0004, 0xA5A5_0008.
REQ-030 inst_ready=0 for 10 cycles -> count saturates at 2, no imem_req after the second fill, head stays pc 0x0; release -> pcs 0x0,0x4,0x8 in order with no loss.
REQ-031 3-cycle memory, redirect_valid with redirect_pc=0x0000_0103 one cycle after imem_req -> late response dropped, next imem_addr=0x0000_0100, next inst_pc=0x100.
REQ-032 Redirect in the same cycle as imem_rvalid and a pop -> FIFO empty, word not pushed, next imem_addr=redirect target.
REQ-033 fetch_pc=0xFFFF_FFFC via redirect -> following request address 0x0000_0000 (wrap).
REQ-034 rstn pulsed low while a request is outstanding -> all outputs at reset values within the reset cycle; next imem_addr=RESET_PC.
